char_text_server: RTL and testbench

- Responder side of the character-display interface: accepts the char_xy / char_line address stream from text-drawing blocks and returns the 8-pixel glyph row on char_pixels.
- Holds a 16x16 text RAM of 7-bit ASCII codes and a 128x16 font ROM.
- Contains a loader FSM so game control can place canned status messages or clear the screen text with a busy/done handshake.
- Sits between the game control logic and the text overlay stage of the VGA pipeline.

---
 rtl/char_text_pkg.sv | 41 ++++
 rtl/char_text_server_font_rom.sv | 78 +++++++
 rtl/char_text_server.sv | 129 ++++++++++++
 tb/tb_char_text_server.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/char_text_pkg.sv
// Shared definitions for the character text server.
//   - text geometry and loader constants
//   - loader FSM state encoding
//   - canned status message indices and the message ROM (ASCII, blank padded)
package char_text_pkg;

  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 16;
  localparam int MSG_LEN   = 16;
  localparam int NUM_MSGS  = 4;

  localparam logic [6:0] BLANK_CHAR = 7'h20;

  localparam logic [1:0] MSG_START  = 2'd0;
  localparam logic [1:0] MSG_X_TURN = 2'd1;
  localparam logic [1:0] MSG_O_TURN = 2'd2;
  localparam logic [1:0] MSG_DRAW   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_t;

  // Message ROM: character idx of message sel. Strings are exactly MSG_LEN
  // characters, first character in the most significant byte.
  function automatic logic [6:0] msg_char(input logic [1:0] sel, input logic [3:0] idx);
    logic [127:0] s;
    logic [7:0]   c;
    case (sel)
      MSG_START:  s = "PRESS START     ";
      MSG_X_TURN: s = "PLAYER X TURN   ";
      MSG_O_TURN: s = "PLAYER O TURN   ";
      default:    s = "GAME DRAW       ";
    endcase
    c = s[8*(15 - int'(idx)) +: 8];
    return c[6:0];
  endfunction

endpackage

// File: rtl/char_text_server_font_rom.sv
// font_rom: 2048x8 synchronous glyph ROM.
//   pclk  - clock
//   rst   - synchronous active-high reset, clears the output register
//   addr  - {code[6:0], line[3:0]}
//   data  - registered glyph row, bit 7 = leftmost pixel, 1-cycle latency
// Glyphs are 8x8 designs doubled vertically to fill the 16-line cell
// (line[3:1] selects the design row). Upper-case letters and digits carry
// glyphs; lower-case letters fold onto upper case. Control codes, 0x7F,
// space and punctuation render blank.
module font_rom (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  function automatic logic [63:0] glyph8x8(input logic [6:0] code);
    case (code)
      7'h30: glyph8x8 = 64'h3C666E7666663C00;
      7'h31: glyph8x8 = 64'h183818181818_7E00;
      7'h32: glyph8x8 = 64'h3C66060C30607E00;
      7'h33: glyph8x8 = 64'h3C66061C06663C00;
      7'h34: glyph8x8 = 64'h060E1E667F060600;
      7'h35: glyph8x8 = 64'h7E607C0606663C00;
      7'h36: glyph8x8 = 64'h3C66607C66663C00;
      7'h37: glyph8x8 = 64'h7E660C1818181800;
      7'h38: glyph8x8 = 64'h3C66663C66663C00;
      7'h39: glyph8x8 = 64'h3C66663E06663C00;
      7'h41: glyph8x8 = 64'h183C66667E666600;
      7'h42: glyph8x8 = 64'h7C66667C66667C00;
      7'h43: glyph8x8 = 64'h3C66606060663C00;
      7'h44: glyph8x8 = 64'h786C6666666C7800;
      7'h45: glyph8x8 = 64'h7E6060786060_7E00;
      7'h46: glyph8x8 = 64'h7E60607860606000;
      7'h47: glyph8x8 = 64'h3C66606E66663C00;
      7'h48: glyph8x8 = 64'h6666667E66666600;
      7'h49: glyph8x8 = 64'h3C18181818183C00;
      7'h4A: glyph8x8 = 64'h1E0C0C0C0C6C3800;
      7'h4B: glyph8x8 = 64'h666C7870786C6600;
      7'h4C: glyph8x8 = 64'h6060606060607E00;
      7'h4D: glyph8x8 = 64'h63777F6B63636300;
      7'h4E: glyph8x8 = 64'h66767E7E6E666600;
      7'h4F: glyph8x8 = 64'h3C66666666663C00;
      7'h50: glyph8x8 = 64'h7C66667C60606000;
      7'h51: glyph8x8 = 64'h3C666666663C0E00;
      7'h52: glyph8x8 = 64'h7C66667C786C6600;
      7'h53: glyph8x8 = 64'h3C66603C06663C00;
      7'h54: glyph8x8 = 64'h7E18181818181800;
      7'h55: glyph8x8 = 64'h6666666666663C00;
      7'h56: glyph8x8 = 64'h66666666663C1800;
      7'h57: glyph8x8 = 64'h6363636B7F776300;
      7'h58: glyph8x8 = 64'h66663C183C666600;
      7'h59: glyph8x8 = 64'h6666663C18181800;
      7'h5A: glyph8x8 = 64'h7E060C1830607E00;
      default: glyph8x8 = 64'h0;
    endcase
  endfunction

  logic [6:0]  code;
  logic [6:0]  code_u;
  logic [63:0] shifted;
  logic [7:0]  row_bits;

  always_comb begin
    code   = addr[10:4];
    code_u = code;
    if (code >= 7'h61 && code <= 7'h7A) code_u = code - 7'h20;
    // Bring design row addr[3:1] to the top byte.
    shifted  = glyph8x8(code_u) << {addr[3:1], 3'b000};
    row_bits = shifted[63:56];
  end

  always_ff @(posedge pclk) begin
    if (rst) data <= 8'h00;
    else     data <= row_bits;
  end

endmodule

// File: rtl/char_text_server.sv
// char_text_server: text RAM + font ROM responder for the text overlay.
//   pclk, rst    - pixel clock, synchronous active-high reset
//   char_xy      - {row[3:0], col[3:0]} read address
//   char_line    - glyph line within the cell
//   char_pixels  - glyph row, valid 2 cycles after char_xy/char_line
//   clr_req      - strobe: fill the text RAM with BLANK_CHAR (256 cycles)
//   load_req     - strobe: write message msg_sel into row msg_row (16 cycles)
//   msg_sel      - message index, sampled with load_req
//   msg_row      - destination row, sampled with load_req
//   busy         - high in every loader write cycle
//   done         - one-cycle pulse after the last write of a load/clear
// Requests are accepted only in IDLE; anything arriving otherwise is dropped.
// clr_req wins when both requests arrive together. Reads are served every
// cycle regardless of the loader; a read of the cell written in the same
// cycle returns the old code.
module char_text_server
  import char_text_pkg::*;
(
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  input  logic [3:0] char_line,
  output logic [7:0] char_pixels,
  input  logic       clr_req,
  input  logic       load_req,
  input  logic [1:0] msg_sel,
  input  logic [3:0] msg_row,
  output logic       busy,
  output logic       done
);

  // Text RAM is deliberately not reset so it maps onto block RAM.
  logic [6:0] text_ram [TEXT_COLS*TEXT_ROWS];
  logic [6:0] code_d1;
  logic [3:0] line_d1;

  logic       wr_en;
  logic [7:0] wr_addr;
  logic [6:0] wr_data;

  ld_state_t  state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] row_q, row_d;

  // Read stage 1 and the loader write share one port-pair; non-blocking
  // update gives read-before-write on an address collision.
  always_ff @(posedge pclk) begin
    if (wr_en) text_ram[wr_addr] <= wr_data;
    code_d1 <= text_ram[char_xy];
    line_d1 <= char_line;
  end

  // Read stage 2.
  font_rom u_font_rom (
    .pclk (pclk),
    .rst  (rst),
    .addr ({code_d1, line_d1}),
    .data (char_pixels)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      sel_q   <= 2'd0;
      row_q   <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      // Registered from the next state so both line up with the state.
      busy    <= (state_d == ST_LOAD) || (state_d == ST_CLEAR);
      done    <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    row_d   = row_q;
    wr_en   = 1'b0;
    wr_addr = idx_q;
    wr_data = BLANK_CHAR;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = 8'd0;
        end else if (load_req) begin
          state_d = ST_LOAD;
          idx_d   = 8'd0;
          sel_d   = msg_sel;
          row_d   = msg_row;
        end
      end
      ST_LOAD: begin
        wr_en   = 1'b1;
        wr_addr = {row_q, idx_q[3:0]};
        wr_data = msg_char(sel_q, idx_q[3:0]);
        if (idx_q == 8'(MSG_LEN - 1)) begin
          state_d = ST_DONE;
          idx_d   = 8'd0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_data = BLANK_CHAR;
        if (idx_q == 8'hFF) begin
          state_d = ST_DONE;
          idx_d   = 8'd0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_char_text_server.sv
// Directed testbench for char_text_server.
module tb_char_text_server;

  logic       pclk;
  logic       rst;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic [7:0] char_pixels;
  logic       clr_req;
  logic       load_req;
  logic [1:0] msg_sel;
  logic [3:0] msg_row;
  logic       busy;
  logic       done;

  int n_pass;
  int n_total;

  char_text_server dut (
    .pclk        (pclk),
    .rst         (rst),
    .char_xy     (char_xy),
    .char_line   (char_line),
    .char_pixels (char_pixels),
    .clr_req     (clr_req),
    .load_req    (load_req),
    .msg_sel     (msg_sel),
    .msg_row     (msg_row),
    .busy        (busy),
    .done        (done)
  );

  // Clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // Called at cycle 0 with the request already driven. Checks busy for
  // cycles 1..n_busy, done in cycle n_busy+1 only. load_req is re-driven
  // high in cycles inj_a / inj_b (0 = unused) to probe request dropping.
  task automatic watch_op(input string tag, input int n_busy, input int inj_a, input int inj_b);
    for (int c = 1; c <= n_busy + 2; c++) begin
      tick();
      clr_req  = 1'b0;
      load_req = (c == inj_a) || (c == inj_b);
      if (load_req) begin
        msg_sel = 2'd3;
        msg_row = 4'd7;
      end
      if (c <= n_busy) begin
        check({tag, "_busy"}, {7'd0, busy}, 8'd1);
        check({tag, "_done_early"}, {7'd0, done}, 8'd0);
      end else if (c == n_busy + 1) begin
        check({tag, "_done"}, {7'd0, done}, 8'd1);
        check({tag, "_busy_at_done"}, {7'd0, busy}, 8'd0);
      end else begin
        check({tag, "_done_once"}, {7'd0, done}, 8'd0);
      end
    end
    load_req = 1'b0;
  endtask

  task automatic quiet_window(input string tag, input int n);
    int pulses;
    int busies;
    pulses = 0;
    busies = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (done) pulses++;
      if (busy) busies++;
    end
    check({tag, "_no_done"}, 8'(pulses), 8'd0);
    check({tag, "_no_busy"}, 8'(busies), 8'd0);
  endtask

  task automatic read_cell(input string tag, input logic [7:0] xy, input logic [3:0] line,
                           input logic [7:0] exp);
    char_xy   = xy;
    char_line = line;
    tick();
    tick();
    check(tag, char_pixels, exp);
  endtask

  // One address per cycle along a row; result expected exactly 2 cycles later.
  task automatic stream_row(input string tag, input logic [3:0] row, input logic [3:0] line,
                            input int len, input logic [7:0] exp [16]);
    char_line = line;
    for (int i = 0; i < len + 2; i++) begin
      if (i < len) char_xy = {row, 4'(i)};
      if (i >= 2) check(tag, char_pixels, exp[i-2]);
      tick();
    end
  endtask

  logic [7:0] exp_row2 [16];
  logic [7:0] exp_row9 [16];

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    char_xy   = 8'h00;
    char_line = 4'h0;
    clr_req   = 1'b0;
    load_req  = 1'b0;
    msg_sel   = 2'd0;
    msg_row   = 4'd0;

    // Row 2 line 4 after "PLAYER X TURN": P L A Y E R _ X _ T U R N
    exp_row2 = '{8'h66, 8'h60, 8'h66, 8'h66, 8'h60, 8'h66, 8'h00, 8'h3C,
                 8'h00, 8'h18, 8'h66, 8'h66, 8'h7E, 8'h00, 8'h00, 8'h00};
    // Row 9 line 4: "GAME DRA" new, then tail of "PLAYER O TURN   " kept
    exp_row9 = '{8'h60, 8'h66, 8'h7F, 8'h60, 8'h00, 8'h66, 8'h66, 8'h66,
                 8'h00, 8'h18, 8'h66, 8'h66, 8'h7E, 8'h00, 8'h00, 8'h00};

    // Reset
    tick(); tick(); tick();
    check("rst_pixels", char_pixels, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    rst = 1'b0;
    tick();

    // Full clear, then random reads are blank
    clr_req = 1'b1;
    watch_op("clear", 256, 0, 0);
    for (int k = 0; k < 4; k++)
      read_cell("clear_read", 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 8'h00);

    // Load "PLAYER X TURN" into row 2
    msg_sel  = 2'd1;
    msg_row  = 4'd2;
    load_req = 1'b1;
    watch_op("load_x", 16, 0, 0);
    read_cell("P_line5", 8'h20, 4'h5, 8'h66);
    read_cell("P_line0", 8'h20, 4'h0, 8'h7C);
    read_cell("P_line1", 8'h20, 4'h1, 8'h7C);
    read_cell("P_line15", 8'h20, 4'hF, 8'h00);
    read_cell("pad_2F", 8'h2F, 4'h5, 8'h00);

    // Back-to-back reads, no bubbles
    stream_row("stream_row2", 4'd2, 4'h4, 13, exp_row2);

    // Simultaneous clear+load: clear wins; loads during busy and DONE dropped
    msg_sel  = 2'd1;
    msg_row  = 4'd5;
    clr_req  = 1'b1;
    load_req = 1'b1;
    watch_op("clr_prio", 256, 10, 257);
    quiet_window("clr_prio_after", 24);
    read_cell("row5_blank", 8'h50, 4'h4, 8'h00);
    read_cell("row7_blank", 8'h70, 4'h4, 8'h00);
    read_cell("row2_cleared", 8'h20, 4'h4, 8'h00);

    // Prior contents for row 9, then reset in load cycle 8
    msg_sel  = 2'd2;
    msg_row  = 4'd9;
    load_req = 1'b1;
    watch_op("load_o", 16, 0, 0);
    msg_sel  = 2'd3;
    load_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      load_req = 1'b0;
    end
    check("mid_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_busy", {7'd0, busy}, 8'd0);
    check("rst_mid_done", {7'd0, done}, 8'd0);
    rst = 1'b0;
    quiet_window("rst_mid_after", 20);
    stream_row("row9_partial", 4'd9, 4'h4, 16, exp_row9);

    // Read-before-write on cell 0x90 (old 'G', new 'P')
    char_xy   = 8'h90;
    char_line = 4'h4;
    msg_sel   = 2'd0;
    msg_row   = 4'd9;
    load_req  = 1'b1;
    tick();
    load_req = 1'b0;
    tick();
    tick();
    check("collide_old", char_pixels, 8'h60);
    tick();
    check("collide_new", char_pixels, 8'h66);
    for (int c = 5; c <= 17; c++) tick();
    check("collide_load_done", {7'd0, done}, 8'd1);
    read_cell("row9_S", 8'h93, 4'h4, 8'h60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
